// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction cache and the decode stage.
// master = fetch unit side, slave = cache/decode environment side.
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef InstWidth
`define InstWidth 32
`endif

interface fetch_unit_if #(
    parameter int ADDR = `AddrWidth,
    parameter int INST = `InstWidth
);
    logic            fetch_e_;
    logic [ADDR-1:0] fetch_pc;
    logic            ic_e_;
    logic [ADDR-1:0] ic_pc;
    logic [INST-1:0] ic_inst;
    logic            inst_e_;
    logic [ADDR-1:0] inst_pc;
    logic [INST-1:0] inst;
    logic            dec_stall;
    logic            br_e_;
    logic [ADDR-1:0] br_pc;

    modport master (
        output fetch_e_, fetch_pc, inst_e_, inst_pc, inst,
        input  ic_e_, ic_pc, ic_inst, dec_stall, br_e_, br_pc
    );

    modport slave (
        input  fetch_e_, fetch_pc, inst_e_, inst_pc, inst,
        output ic_e_, ic_pc, ic_inst, dec_stall, br_e_, br_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential PC requests, buffers in-order cache responses
// in a small circular buffer, and flushes/discards stale responses on redirect.
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef InstWidth
`define InstWidth 32
`endif

module fetch_unit #(
    parameter int              ADDR     = `AddrWidth,
    parameter int              INST     = `InstWidth,
    parameter logic [ADDR-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam int              PW      = $clog2(DEPTH);
    localparam logic [ADDR-1:0] STEP    = ADDR'(INST / 8);
    localparam logic [CW:0]     DEPTH_L = DEPTH[CW:0];

    logic [ADDR-1:0] pc_q, pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   disc_q, disc_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;

    logic [ADDR-1:0] pc_mem   [DEPTH];
    logic [INST-1:0] inst_mem [DEPTH];

    logic [CW:0] occupancy;
    logic        fire, redirect, resp, push, drop, pop, has_entry;

    // Space is reserved at request time, so a response can always be pushed.
    assign occupancy = {1'b0, count_q} + {1'b0, out_q};
    assign fire      = !reset && bus.br_e_ && (occupancy < DEPTH_L);
    assign redirect  = !reset && !bus.br_e_;
    assign resp      = !reset && !bus.ic_e_ && (out_q != '0);
    assign push      = resp && !redirect && (disc_q == '0);
    assign drop      = resp && !redirect && (disc_q != '0);
    assign has_entry = (count_q != '0);
    assign pop       = !reset && has_entry && !bus.dec_stall && !redirect;

    assign bus.fetch_e_ = !fire;
    assign bus.fetch_pc = pc_q;
    assign bus.inst_e_  = !(has_entry && !reset);
    assign bus.inst_pc  = reset ? '0 : pc_mem[head_q];
    assign bus.inst     = reset ? '0 : inst_mem[head_q];

    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        out_d   = out_q + CW'(fire) - CW'(resp);
        disc_d  = disc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (redirect) begin
            // Everything still in flight is now stale and must be dropped on arrival.
            pc_d    = bus.br_pc;
            count_d = '0;
            head_d  = tail_q;
            disc_d  = out_q - CW'(resp);
        end else begin
            if (fire) begin
                pc_d = pc_q + STEP;
            end
            if (drop) begin
                disc_d = disc_q - 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            if (push) begin
                tail_d = tail_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
            out_q   <= '0;
            disc_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]   <= bus.ic_pc;
            inst_mem[tail_q] <= bus.ic_inst;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle, an in-order
// cache model with programmable latency, and directed scenarios with literal checks.
module tb_fetch_unit;
    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int          DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR(32), .INST(32)) fif ();

    fetch_unit #(
        .ADDR(32), .INST(32), .RESET_PC(RPC), .DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (fif)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int lat   = 1;
    bit spurious = 1'b0;

    logic [31:0] pend_pc [$];
    int          pend_due[$];
    logic [31:0] fired   [$];
    int          fired_cyc[$];
    logic [31:0] deliv   [$];
    int          deliv_cyc[$];

    // Reference model: program counter, queue of buffered entries, in-flight and stale counts.
    logic [31:0] m_pc;
    logic [31:0] mq_pc  [$];
    logic [31:0] mq_inst[$];
    int          m_out  = 0;
    int          m_disc = 0;

    function automatic logic [31:0] ifn(logic [31:0] pc);
        return pc ^ 32'hC0DE_5A5A;
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        bit m_fire;
        bit resp;
        // cache response for this cycle
        if (pend_pc.size() > 0 && pend_due[0] <= cyc) begin
            fif.ic_e_   = 1'b0;
            fif.ic_pc   = pend_pc[0];
            fif.ic_inst = ifn(pend_pc[0]);
            void'(pend_pc.pop_front());
            void'(pend_due.pop_front());
        end else if (spurious) begin
            fif.ic_e_   = 1'b0;
            fif.ic_pc   = 32'h0000_BAD0;
            fif.ic_inst = 32'hDEAD_DEAD;
        end else begin
            fif.ic_e_ = 1'b1;
        end
        spurious = 1'b0;
        if (reset) begin
            pend_pc.delete();
            pend_due.delete();
        end
        #1;
        m_fire = !reset && fif.br_e_ && (mq_pc.size() + m_out < DEPTH);
        check("fetch_e_", 64'(fif.fetch_e_), 64'(!m_fire));
        check("inst_e_", 64'(fif.inst_e_), 64'(reset || mq_pc.size() == 0));
        if (reset) begin
            check("inst_pc_rst", 64'(fif.inst_pc), 64'd0);
            check("inst_rst", 64'(fif.inst), 64'd0);
        end else begin
            check("fetch_pc", 64'(fif.fetch_pc), 64'(m_pc));
            if (mq_pc.size() > 0) begin
                check("inst_pc", 64'(fif.inst_pc), 64'(mq_pc[0]));
                check("inst", 64'(fif.inst), 64'(mq_inst[0]));
            end
        end
        if (!fif.fetch_e_) begin
            pend_pc.push_back(fif.fetch_pc);
            pend_due.push_back(cyc + lat);
            fired.push_back(fif.fetch_pc);
            fired_cyc.push_back(cyc);
        end
        if (!reset && !fif.inst_e_ && !fif.dec_stall && fif.br_e_) begin
            deliv.push_back(fif.inst_pc);
            deliv_cyc.push_back(cyc);
            $display("deliver cyc=%0d pc=%h inst=%h", cyc, fif.inst_pc, fif.inst);
        end
        if (reset) begin
            m_pc = RPC;
            mq_pc.delete();
            mq_inst.delete();
            m_out  = 0;
            m_disc = 0;
        end else begin
            resp = !fif.ic_e_ && m_out > 0;
            if (!fif.br_e_) begin
                mq_pc.delete();
                mq_inst.delete();
                m_disc = m_out - int'(resp);
                m_out  = m_out - int'(resp);
                m_pc   = fif.br_pc;
            end else begin
                if (mq_pc.size() > 0 && !fif.dec_stall) begin
                    void'(mq_pc.pop_front());
                    void'(mq_inst.pop_front());
                end
                if (resp) begin
                    if (m_disc > 0) m_disc--;
                    else begin
                        mq_pc.push_back(fif.ic_pc);
                        mq_inst.push_back(fif.ic_inst);
                    end
                    m_out--;
                end
                if (m_fire) begin
                    m_out++;
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    initial begin
        int f0;
        int d0;
        bit hit;
        logic [31:0] a;
        reset         = 1'b1;
        fif.br_e_     = 1'b1;
        fif.br_pc     = '0;
        fif.dec_stall = 1'b0;
        fif.ic_e_     = 1'b1;
        fif.ic_pc     = '0;
        fif.ic_inst   = '0;
        @(negedge clk);

        // streaming, latency 1
        do_reset(2);
        lat = 1;
        f0 = fired.size();
        d0 = deliv.size();
        repeat (12) tick();
        check("stream_nfire", 64'(fired.size() - f0), 64'd12);
        check("stream_f0", 64'(fired[f0]), 64'h100);
        check("stream_f1", 64'(fired[f0+1]), 64'h104);
        check("stream_f2", 64'(fired[f0+2]), 64'h108);
        check("stream_d0", 64'(deliv[d0]), 64'h100);
        check("stream_d1", 64'(deliv[d0+1]), 64'h104);
        check("stream_lag", 64'(deliv_cyc[d0] - fired_cyc[f0]), 64'd2);

        // backpressure, latency 2
        do_reset(1);
        lat = 2;
        fif.dec_stall = 1'b1;
        f0 = fired.size();
        repeat (10) tick();
        check("bp_nfire", 64'(fired.size() - f0), 64'd4);
        check("bp_last", 64'(fired[f0+3]), 64'h10C);
        check("bp_idle", 64'(fif.fetch_e_), 64'd1);
        spurious = 1'b1;
        tick();
        fif.dec_stall = 1'b0;
        d0 = deliv.size();
        repeat (8) tick();
        for (int i = 0; i < 4; i++)
            check("bp_pop", 64'(deliv[d0+i]), 64'(32'h100 + 32'(4 * i)));
        check("bp_resume", 64'(fired[f0+4]), 64'h110);

        // redirect with two requests in flight
        do_reset(1);
        lat = 3;
        repeat (2) tick();
        fif.br_e_ = 1'b0;
        fif.br_pc = 32'h2000;
        tick();
        fif.br_e_ = 1'b1;
        check("br2_disc", 64'(m_disc), 64'd2);
        check("br2_out", 64'(m_out), 64'd2);
        d0 = deliv.size();
        repeat (12) tick();
        check("br2_first", 64'(deliv[d0]), 64'h2000);

        // redirect in the same cycle as a response, then back-to-back redirects
        do_reset(1);
        lat = 3;
        fif.dec_stall = 1'b1;
        repeat (3) tick();
        fif.br_e_ = 1'b0;
        fif.br_pc = 32'h3000;
        tick();
        fif.br_e_ = 1'b1;
        check("br3_disc", 64'(m_disc), 64'd2);
        check("br3_cnt", 64'(mq_pc.size()), 64'd0);
        fif.dec_stall = 1'b0;
        d0 = deliv.size();
        repeat (12) tick();
        check("br3_first", 64'(deliv[d0]), 64'h3000);
        fif.br_e_ = 1'b0;
        fif.br_pc = 32'h4000;
        tick();
        fif.br_pc = 32'h5000;
        tick();
        fif.br_e_ = 1'b1;
        d0 = deliv.size();
        repeat (12) tick();
        check("br_last_wins", 64'(deliv[d0]), 64'h5000);

        // address wrap and buffer pointer wrap over 20 instructions
        lat = 1;
        fif.br_e_ = 1'b0;
        fif.br_pc = 32'hFFFF_FFF8;
        tick();
        fif.br_e_ = 1'b1;
        d0 = deliv.size();
        for (int i = 0; i < 40; i++) begin
            fif.dec_stall = (i % 5 == 3) || (i % 7 == 2);
            tick();
        end
        fif.dec_stall = 1'b0;
        check("wrap_n", 64'(deliv.size() - d0 >= 20), 64'd1);
        check("wrap_zero", 64'(deliv[d0+2]), 64'h0);
        for (int i = 0; i < 20; i++) begin
            a = 32'hFFFF_FFF8 + 32'(4 * i);
            check("wrap_seq", 64'(deliv[d0+i]), 64'(a));
        end

        // reset while three entries are buffered
        fif.dec_stall = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (mq_pc.size() == 3) hit = 1'b1;
            else tick();
        end
        check("rst_mid_reach", 64'(hit), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        f0 = fired.size();
        tick();
        check("rst_mid_fire", 64'(fired.size() - f0), 64'd1);
        check("rst_mid_pc", 64'(fired[f0]), 64'(RPC));
        fif.dec_stall = 1'b0;

        // mixed traffic
        for (int i = 0; i < 300; i++) begin
            fif.dec_stall = ($urandom_range(0, 3) == 0);
            if (pend_pc.size() == 0) lat = $urandom_range(1, 3);
            if ($urandom_range(0, 15) == 0) begin
                fif.br_e_ = 1'b0;
                fif.br_pc = {$urandom_range(0, 65535), 16'h0} | 32'(4 * $urandom_range(0, 255));
            end else begin
                fif.br_e_ = 1'b1;
            end
            tick();
        end
        fif.br_e_ = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
